// File: rtl/axi_fifo_wr_arbiter.sv
// rtl/axi_fifo_wr_arbiter.sv - round-robin, burst-locked write arbiter in front of an async FIFO
// Optional idle-while-locked watchdog enabled by defining AXI_ARB_WDOG_EN.
module axi_fifo_wr_arbiter #(
    parameter int  NUM_REQ     = 4,
    parameter int  DATA_WIDTH  = 64,
    parameter int  WDOG_CYCLES = 256,
    localparam int ID_WIDTH    = $clog2(NUM_REQ),
    localparam int FIFO_WIDTH  = ID_WIDTH + 1 + DATA_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_wr_en_o,
    output logic [FIFO_WIDTH-1:0]         fifo_wr_data_o,
    input  logic                          fifo_full_i,
    output logic [ID_WIDTH-1:0]           grant_id_o,
    output logic                          busy_o,
    output logic                          wdog_err_o
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_params
        $error("axi_fifo_wr_arbiter: parameter out of range");
    end

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;

    logic                  sel_found;
    logic [ID_WIDTH-1:0]   sel_id;
    logic [ID_WIDTH:0]     search_idx;
    logic                  beat_last;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  xfer;

`ifdef AXI_ARB_WDOG_EN
    logic [15:0]           wdog_q, wdog_d;
    logic                  wdog_err_q, wdog_err_d;
`endif

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : id + ID_WIDTH'(1);
    endfunction

    // While locked only the owner is eligible; otherwise search valids from rr_ptr upward.
    always_comb begin
        sel_found  = 1'b0;
        sel_id     = '0;
        search_idx = '0;
        if (state_q == S_LOCKED) begin
            sel_found = 1'b1;
            sel_id    = grant_id_q;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                search_idx = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(i);
                if (search_idx >= (ID_WIDTH + 1)'(NUM_REQ)) begin
                    search_idx = search_idx - (ID_WIDTH + 1)'(NUM_REQ);
                end
                if (!sel_found && req_valid_i[search_idx[ID_WIDTH-1:0]]) begin
                    sel_found = 1'b1;
                    sel_id    = search_idx[ID_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        beat_last   = 1'b0;
        beat_data   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_found && sel_id == ID_WIDTH'(k)) begin
                req_ready_o[k] = !fifo_full_i && !rst_i;
                beat_last      = req_last_i[k];
                beat_data      = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign xfer           = |(req_valid_i & req_ready_o);
    assign fifo_wr_en_o   = xfer;
    assign fifo_wr_data_o = {sel_id, beat_last, beat_data};
    assign grant_id_o     = grant_id_q;
    assign busy_o         = (state_q == S_LOCKED);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
`ifdef AXI_ARB_WDOG_EN
        wdog_d     = wdog_q;
        wdog_err_d = wdog_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (beat_last) begin
                        rr_ptr_d = next_id(sel_id);
                    end else begin
                        state_d    = S_LOCKED;
                        grant_id_d = sel_id;
                    end
                end
            end
            S_LOCKED: begin
                if (xfer && beat_last) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = next_id(grant_id_q);
                end
`ifdef AXI_ARB_WDOG_EN
                // Only cycles where the owner could have sent but did not count as stalled.
                if (xfer) begin
                    wdog_d = '0;
                end else if (!fifo_full_i) begin
                    if (wdog_q == 16'(WDOG_CYCLES - 1)) begin
                        state_d    = S_IDLE;
                        rr_ptr_d   = next_id(grant_id_q);
                        wdog_err_d = 1'b1;
                        wdog_d     = '0;
                    end else begin
                        wdog_d = wdog_q + 16'd1;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

`ifdef AXI_ARB_WDOG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err_o = wdog_err_q;
`else
    assign wdog_err_o = 1'b0;
`endif

endmodule
